cond_select_arbiter: RTL
========================

Name: cond_select_arbiter

Overview:
- Responder side of the condition-select checks: requesters present a request vector; on a start strobe the block selects one requester and grants it under UNIQUE, UNIQUE0 or PRIORITY semantics.
- Ambiguity is flagged as an error: multiple requests in UNIQUE/UNIQUE0 mode, or no request in UNIQUE/PRIORITY mode.
- The grant is held until the granted requester returns done, or until a watchdog expires.
- Sits between bench/DUT requesters and a shared resource; also used as a self-checking arbitration reference.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- IDW, $clog2(N_REQ), width of the grant index
- TIMEOUT, 16, maximum number of grant cycles before revocation (>=2)
- CNTW, 8, width of the saturating error counter

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  0=PRIORITY, 1=UNIQUE, 2=UNIQUE0, 3=reserved
- arb_start  in  1  sample req and arbitrate this cycle
- req  in  N_REQ  request vector
- done  in  1  granted requester releases the grant
- err_clr  in  1  clears err_cnt
- gnt  out  N_REQ  one-hot grant; zero when none
- gnt_id  out  IDW  index of the granted requester
- gnt_valid  out  1  a grant is active
- busy  out  1  FSM not in IDLE
- err_multi  out  1  1-cycle pulse: more than one request in UNIQUE/UNIQUE0 mode
- err_none  out  1  1-cycle pulse: zero requests in UNIQUE/PRIORITY mode
- err_timeout  out  1  1-cycle pulse: grant revoked by the watchdog
- err_mode  out  1  1-cycle pulse: reserved mode sampled
- err_cnt  out  CNTW  saturating count of all error pulses

Behaviour:
- Reset (rst=1 at an edge): FSM=IDLE; gnt=0, gnt_id=0, gnt_valid=0, busy=0; all err_* pulses=0; err_cnt=0; watchdog=0. Reset mid-grant drops the grant on the next edge.
- FSM states: IDLE, GRANT.
- IDLE, arb_start=1: req and mode are sampled at edge T. Results (grant and error pulses) are visible from T+1.
  - Selected index is always the lowest set bit of req.
  - PRIORITY: >=1 request -> grant; 0 requests -> err_none, stay IDLE.
  - UNIQUE: exactly 1 -> grant; >1 -> err_multi AND grant lowest index; 0 -> err_none, stay IDLE.
  - UNIQUE0: exactly 1 -> grant; >1 -> err_multi AND grant lowest index; 0 -> no error, stay IDLE.
  - mode=3: behave as PRIORITY and pulse err_mode.
- IDLE -> GRANT on a grant: gnt=onehot(idx), gnt_id=idx, gnt_valid=1, busy=1; watchdog loads 0.
- GRANT:
  - req and mode are not re-sampled; arb_start is ignored (no queueing, no error).
  - Watchdog increments every cycle.
  - done=1 -> IDLE at the next edge; gnt=0 and gnt_valid=0 from that edge.
  - Watchdog reaching TIMEOUT-1 without done -> IDLE and err_timeout pulse. The grant lasts exactly TIMEOUT cycles.
  - done and timeout on the same edge: done wins, no err_timeout.
- Back-to-back: a grant may re-issue from IDLE at the earliest one cycle after release (one idle cycle minimum).
- done in IDLE: ignored.
- err_cnt:
  - Adds the number of error pulses asserted in the same cycle (up to 2, e.g. err_multi+err_mode cannot coexist; err_none+err_mode can).
  - Saturates at 2^CNTW-1 with no wrap.
  - err_clr zeroes it and has priority over increments in the same cycle.
- Pure sync design; no combinational path from req to gnt.

Decomposition:
- Package cond_sel_pkg:
  - typedef enum logic[1:0] {SEL_PRIORITY, SEL_UNIQUE, SEL_UNIQUE0, SEL_RSVD} sel_mode_e
  - typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e
  - function popcount_gt1
- Sub-module lsb_onehot_enc: combinational lowest-set-bit finder returning {any, multi, idx, onehot}. Instantiated once in cond_select_arbiter.

Test Plan:
- Reset, then mode=UNIQUE, req=4'b0100, arb_start -> next cycle gnt=0100, gnt_id=2, gnt_valid=1, no errors; done=1 -> gnt=0 the following cycle.
- mode=UNIQUE, req=4'b0110 -> err_multi pulses once, gnt=0010, gnt_id=1, err_cnt=1.
- mode=UNIQUE0, req=0 -> no grant, no error pulse, err_cnt unchanged; then mode=PRIORITY, req=0 -> err_none pulse, err_cnt+1.
- mode=PRIORITY, req=4'b1010, done never asserted (TIMEOUT=16) -> gnt held exactly 16 cycles, err_timeout on revocation; arb_start during the grant is ignored.
- mode=3, req=4'b1000 -> gnt_id=3, err_mode pulse; drive 300 errors with CNTW=8 -> err_cnt=255; err_clr together with an error pulse -> err_cnt=0.
- Assert rst during GRANT -> all outputs zero at the next edge; first arb_start after deassertion arbitrates normally.

Source files
------------

// File: rtl/cond_sel_pkg.sv
// Shared types and helpers for the condition-select arbiter.
package cond_sel_pkg;

  // Widest request vector the helpers below are sized for.
  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    SEL_PRIORITY = 2'd0,
    SEL_UNIQUE   = 2'd1,
    SEL_UNIQUE0  = 2'd2,
    SEL_RSVD     = 2'd3
  } sel_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input logic [MAX_REQ-1:0] v);
    return (v & (v - MAX_REQ'(1))) != '0;
  endfunction

endpackage

// File: rtl/cond_select_arbiter_lsb_onehot_enc.sv
// Combinational lowest-set-bit finder: reports any/multi, the index and the one-hot form.
module lsb_onehot_enc
  import cond_sel_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   vec_i,
  output logic           any_o,
  output logic           multi_o,
  output logic [IDW-1:0] idx_o,
  output logic [N-1:0]   onehot_o
);

  logic [MAX_REQ-1:0] vec_ext;

  // Zero-extend to the package helper width; bits beyond N are tied low.
  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
    if (gi < N) begin : g_in
      assign vec_ext[gi] = vec_i[gi];
    end else begin : g_pad
      assign vec_ext[gi] = 1'b0;
    end
  end

  assign any_o    = |vec_i;
  assign multi_o  = popcount_gt1(vec_ext);
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + N'(1));

  // Scan from the top down so the lowest set bit is the last one to write idx.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDW'(i);
    end
  end

endmodule

// File: rtl/cond_select_arbiter.sv
// Condition-select arbiter: grants the lowest requester under PRIORITY/UNIQUE/UNIQUE0
// semantics, flags ambiguous requests, holds the grant until done or watchdog expiry.
module cond_select_arbiter
  import cond_sel_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDW     = $clog2(N_REQ),
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             arb_start,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic             err_clr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             gnt_valid,
  output logic             busy,
  output logic             err_multi,
  output logic             err_none,
  output logic             err_timeout,
  output logic             err_mode,
  output logic [CNTW-1:0]  err_cnt
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             gnt_valid_q;
  logic             busy_q;
  logic [WDW-1:0]   wd_q;
  logic             err_multi_q, err_none_q, err_timeout_q, err_mode_q;
  logic [CNTW-1:0]  err_cnt_q, err_cnt_d;

  logic             take_grant;
  logic             wd_expired;
  logic             err_multi_d, err_none_d, err_timeout_d, err_mode_d;
  logic [2:0]       err_inc;
  logic [CNTW:0]    err_sum;

  logic             enc_any, enc_multi;
  logic [IDW-1:0]   enc_idx;
  logic [N_REQ-1:0] enc_onehot;
  sel_mode_e        mode_s;

  assign mode_s = sel_mode_e'(mode);

  lsb_onehot_enc #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_enc (
    .vec_i    (req),
    .any_o    (enc_any),
    .multi_o  (enc_multi),
    .idx_o    (enc_idx),
    .onehot_o (enc_onehot)
  );

  // Decode arbitration outcome and error pulses for the coming edge.
  always_comb begin
    take_grant  = 1'b0;
    err_multi_d = 1'b0;
    err_none_d  = 1'b0;
    err_mode_d  = 1'b0;
    if (state_q == ST_IDLE && arb_start) begin
      // Every mode grants the lowest requester when anyone is asking.
      take_grant = enc_any;
      case (mode_s)
        SEL_PRIORITY: begin
          err_none_d = ~enc_any;
        end
        SEL_UNIQUE: begin
          err_multi_d = enc_multi;
          err_none_d  = ~enc_any;
        end
        SEL_UNIQUE0: begin
          err_multi_d = enc_multi;
        end
        default: begin
          // Reserved mode falls back to PRIORITY but is reported.
          err_none_d = ~enc_any;
          err_mode_d = 1'b1;
        end
      endcase
    end
    // done on the same edge as expiry is a clean release, not a timeout.
    wd_expired    = (state_q == ST_GRANT) && !done && (wd_q == WD_LAST);
    err_timeout_d = wd_expired;
  end

  // Arbitration FSM with registered grant outputs, watchdog and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      gnt_id_q      <= '0;
      gnt_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      wd_q          <= '0;
      err_multi_q   <= 1'b0;
      err_none_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_mode_q    <= 1'b0;
    end else begin
      err_multi_q   <= err_multi_d;
      err_none_q    <= err_none_d;
      err_timeout_q <= err_timeout_d;
      err_mode_q    <= err_mode_d;
      case (state_q)
        ST_IDLE: begin
          if (take_grant) begin
            state_q     <= ST_GRANT;
            gnt_q       <= enc_onehot;
            gnt_id_q    <= enc_idx;
            gnt_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            wd_q        <= '0;
          end
        end
        ST_GRANT: begin
          if (done || wd_expired) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wd_q        <= '0;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating sum of all error pulses issued on the coming edge; clear wins.
  always_comb begin
    err_inc = 3'(err_multi_d) + 3'(err_none_d) + 3'(err_timeout_d) + 3'(err_mode_d);
    err_sum = {1'b0, err_cnt_q} + (CNTW + 1)'(err_inc);
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_sum[CNTW]) begin
      err_cnt_d = '1;
    end else begin
      err_cnt_d = err_sum[CNTW-1:0];
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign gnt_valid   = gnt_valid_q;
  assign busy        = busy_q;
  assign err_multi   = err_multi_q;
  assign err_none    = err_none_q;
  assign err_timeout = err_timeout_q;
  assign err_mode    = err_mode_q;
  assign err_cnt     = err_cnt_q;

endmodule
